// File: rtl/adder_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered adder between N_REQ requesters.
// Define ADDER_ARBITER_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module adder_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [N_REQ-1:0]       Req,
    input  logic [N_REQ*WIDTH-1:0] Op_A,
    input  logic [N_REQ*WIDTH-1:0] Op_B,
    output logic [N_REQ-1:0]       Gnt,
    output logic [N_REQ-1:0]       Done,
    output logic [WIDTH-1:0]       Res_Sum,
    output logic                   Res_Overflow,
    output logic                   Busy,
    output logic [WIDTH-1:0]       Add_A,
    output logic [WIDTH-1:0]       Add_B,
    output logic                   Add_En,
    input  logic [WIDTH-1:0]       Add_Sum,
    input  logic                   Add_Overflow
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [WIDTH-1:0]   add_a_q, add_a_d;
    logic [WIDTH-1:0]   add_b_q, add_b_d;
    logic               add_en_q, add_en_d;
    logic [WIDTH-1:0]   res_sum_q, res_sum_d;
    logic               res_ovf_q, res_ovf_d;
    logic               busy_q, busy_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   gidx_q, gidx_d;

    logic               sel_valid;
    logic [PTR_W-1:0]   sel_idx;
    logic [PTR_W-1:0]   cand;
    logic [WIDTH-1:0]   op_a_arr [N_REQ];
    logic [WIDTH-1:0]   op_b_arr [N_REQ];

    // Unpack the flat operand buses per requester.
    for (genvar i = 0; i < int'(N_REQ); i++) begin : g_unpack
        assign op_a_arr[i] = Op_A[i*WIDTH +: WIDTH];
        assign op_b_arr[i] = Op_B[i*WIDTH +: WIDTH];
    end

    // First set request searching upward from the pointer, wrapping at N_REQ-1.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = PTR_W'((32'(ptr_q) + k) % N_REQ);
            if (!sel_valid && Req[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_en_d  = 1'b0;
        res_sum_d = res_sum_q;
        res_ovf_d = res_ovf_q;
        ptr_d     = ptr_q;
        gidx_d    = gidx_q;

        case (state_q)
            S_IDLE: begin
                if (sel_valid) begin
                    state_d  = S_ISSUE;
                    gnt_d    = N_REQ'(1) << sel_idx;
                    gidx_d   = sel_idx;
                    add_a_d  = op_a_arr[sel_idx];
                    add_b_d  = op_b_arr[sel_idx];
                    add_en_d = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                res_sum_d = Add_Sum;
                res_ovf_d = Add_Overflow;
                state_d   = S_DONE;
            end
            S_DONE: begin
                done_d  = N_REQ'(1) << gidx_q;
                gnt_d   = '0;
                state_d = S_IDLE;
`ifdef ADDER_ARBITER_FIXED_PRIO_EN
                ptr_d   = '0;
`else
                ptr_d   = (32'(gidx_q) == N_REQ - 1) ? '0 : gidx_q + PTR_W'(1);
`endif
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            add_a_q   <= '0;
            add_b_q   <= '0;
            add_en_q  <= 1'b0;
            res_sum_q <= '0;
            res_ovf_q <= 1'b0;
            busy_q    <= 1'b0;
            ptr_q     <= '0;
            gidx_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            add_en_q  <= add_en_d;
            res_sum_q <= res_sum_d;
            res_ovf_q <= res_ovf_d;
            busy_q    <= busy_d;
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
        end
    end

    assign Gnt          = gnt_q;
    assign Done         = done_q;
    assign Res_Sum      = res_sum_q;
    assign Res_Overflow = res_ovf_q;
    assign Busy         = busy_q;
    assign Add_A        = add_a_q;
    assign Add_B        = add_b_q;
    assign Add_En       = add_en_q;

endmodule
